// File: rtl/reg_port_pkg.sv
// Shared definitions for the register-port master: op codes, FSM state
// encoding and register-file address geometry.
package reg_port_pkg;

  // Register-file address bus width and the command index width.
  localparam int unsigned RfAddrW = 8;
  localparam int unsigned IdxW    = 4;

  typedef enum logic [1:0] {
    OpRead  = 2'd0,
    OpWrite = 2'd1,
    OpMove  = 2'd2,
    OpClear = 2'd3
  } op_e;

  // FSM state encoding.
  typedef logic [2:0] state_t;

  localparam state_t StIdle = 3'd0;
  localparam state_t StRd   = 3'd1;
  localparam state_t StWr   = 3'd2;
  localparam state_t StMvRd = 3'd3;
  localparam state_t StMvWr = 3'd4;
  localparam state_t StClr  = 3'd5;
  localparam state_t StRsp  = 3'd6;

  // Zero-extend a command index onto the register-file address bus.
  function automatic logic [RfAddrW-1:0] idx_to_addr(input logic [IdxW-1:0] idx);
    return {{(RfAddrW - IdxW){1'b0}}, idx};
  endfunction

endpackage

// File: rtl/reg_port_master_if.sv
// Command, response and register-file bus of the register-port master.
// The master modport is the view of reg_port_master itself; the slave
// modport is the view of whatever drives commands and models the file.
interface reg_port_master_if;
  import reg_port_pkg::*;

  // Command channel
  logic               cmd_valid;
  logic               cmd_ready;
  logic [1:0]         cmd_op;
  logic [IdxW-1:0]    cmd_addr;
  logic [IdxW-1:0]    cmd_addr2;
  logic [7:0]         cmd_wdata;

  // Response channel
  logic               rsp_valid;
  logic               rsp_ready;
  logic [7:0]         rsp_data;

  // Status
  logic               busy;

  // Register-file port
  logic               rf_write;
  logic               rf_read;
  logic [RfAddrW-1:0] rf_addr;
  logic [7:0]         rf_wdata;
  logic [7:0]         rf_rdata;

  modport master (
    input  cmd_valid, cmd_op, cmd_addr, cmd_addr2, cmd_wdata,
    input  rsp_ready,
    input  rf_rdata,
    output cmd_ready,
    output rsp_valid, rsp_data,
    output busy,
    output rf_write, rf_read, rf_addr, rf_wdata
  );

  modport slave (
    output cmd_valid, cmd_op, cmd_addr, cmd_addr2, cmd_wdata,
    output rsp_ready,
    output rf_rdata,
    input  cmd_ready,
    input  rsp_valid, rsp_data,
    input  busy,
    input  rf_write, rf_read, rf_addr, rf_wdata
  );

endinterface

// File: rtl/reg_port_master.sv
// Register-port master: accepts one command at a time, sequences the
// register-file accesses it needs (read, write, move, clear sweep) and
// returns a single response word, held until the consumer takes it.
module reg_port_master
  import reg_port_pkg::*;
#(
  parameter int unsigned RF_DEPTH   = 16,
  parameter logic [7:0]  CLEAR_DATA = 8'h00
) (
  input logic               clk,
  input logic               rst,
  reg_port_master_if.master bus
);

  // Last index visited by the CLEAR sweep.
  localparam logic [RfAddrW-1:0] CntLast = RfAddrW'(RF_DEPTH - 1);

  state_t             state_q,    state_d;
  op_e                op_q,       op_d;
  logic [IdxW-1:0]    addr_q,     addr_d;
  logic [IdxW-1:0]    addr2_q,    addr2_d;
  logic [7:0]         wdata_q,    wdata_d;
  logic [7:0]         rsp_data_q, rsp_data_d;
  logic [RfAddrW-1:0] cnt_q,      cnt_d;

  logic               rf_write;
  logic               rf_read;
  logic [RfAddrW-1:0] rf_addr;
  logic [7:0]         rf_wdata;

  // State and holding registers, synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      op_q       <= OpRead;
      addr_q     <= '0;
      addr2_q    <= '0;
      wdata_q    <= '0;
      rsp_data_q <= 8'h00;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      addr_q     <= addr_d;
      addr2_q    <= addr2_d;
      wdata_q    <= wdata_d;
      rsp_data_q <= rsp_data_d;
      cnt_q      <= cnt_d;
    end
  end

  // Next-state logic: command capture, access sequencing and response hold.
  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    addr_d     = addr_q;
    addr2_d    = addr2_q;
    wdata_d    = wdata_q;
    rsp_data_d = rsp_data_q;
    cnt_d      = cnt_q;

    case (state_q)
      StIdle: begin
        // cmd_ready is high throughout IDLE, so cmd_valid alone is the accept.
        if (bus.cmd_valid) begin
          op_d    = op_e'(bus.cmd_op);
          addr_d  = bus.cmd_addr;
          addr2_d = bus.cmd_addr2;
          wdata_d = bus.cmd_wdata;
          unique case (op_e'(bus.cmd_op))
            OpRead:  state_d = StRd;
            OpWrite: state_d = StWr;
            OpMove:  state_d = StMvRd;
            OpClear: begin
              state_d = StClr;
              cnt_d   = '0;
            end
          endcase
        end
      end

      // Both read states capture the file output; a MOVE then writes it back.
      StRd, StMvRd: begin
        rsp_data_d = bus.rf_rdata;
        state_d    = (op_q == OpMove) ? StMvWr : StRsp;
      end

      StWr: begin
        rsp_data_d = wdata_q;
        state_d    = StRsp;
      end

      StMvWr: begin
        state_d = StRsp;
      end

      StClr: begin
        if (cnt_q == CntLast) begin
          cnt_d      = '0;
          rsp_data_d = CLEAR_DATA;
          state_d    = StRsp;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      StRsp: begin
        if (bus.rsp_ready) begin
          state_d = StIdle;
        end
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Register-file strobes, decoded from state and holding registers only.
  always_comb begin
    rf_write = 1'b0;
    rf_read  = 1'b0;
    rf_addr  = '0;
    rf_wdata = '0;

    case (state_q)
      StRd, StMvRd: begin
        rf_read = 1'b1;
        rf_addr = idx_to_addr(addr_q);
      end
      StWr: begin
        rf_write = 1'b1;
        rf_addr  = idx_to_addr(addr_q);
        rf_wdata = wdata_q;
      end
      StMvWr: begin
        rf_write = 1'b1;
        rf_addr  = idx_to_addr(addr2_q);
        rf_wdata = rsp_data_q;
      end
      StClr: begin
        rf_write = 1'b1;
        rf_addr  = cnt_q;
        rf_wdata = CLEAR_DATA;
      end
      default: begin
        rf_write = 1'b0;
      end
    endcase
  end

  assign bus.cmd_ready = (state_q == StIdle);
  assign bus.rsp_valid = (state_q == StRsp);
  assign bus.rsp_data  = rsp_data_q;
  assign bus.busy      = (state_q != StIdle);
  assign bus.rf_write  = rf_write;
  assign bus.rf_read   = rf_read;
  assign bus.rf_addr   = rf_addr;
  assign bus.rf_wdata  = rf_wdata;

endmodule

// File: tb/tb_reg_port_master.sv
// Bench for reg_port_master: behavioural register file, reference model of
// the file contents, and a response scoreboard checked at each handshake.
module tb_reg_port_master;
  import reg_port_pkg::*;

  localparam int unsigned Depth   = 16;
  localparam logic [7:0]  ClrData = 8'h00;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  reg_port_master_if bus ();

  reg_port_master #(
    .RF_DEPTH  (Depth),
    .CLEAR_DATA(ClrData)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // Register file attached to the port; undriven read bus modelled as zero.
  logic [7:0] rf_mem [Depth];
  always @(posedge clk) if (bus.rf_write) rf_mem[bus.rf_addr[3:0]] <= bus.rf_wdata;
  assign bus.rf_rdata = bus.rf_read ? rf_mem[bus.rf_addr[3:0]] : 8'h00;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;
  int both_hi = 0;

  logic [7:0] exp_mem [Depth];
  logic [7:0] sb [$];
  int         wr_cyc [$];
  logic [7:0] wr_addr [$];
  logic [7:0] wr_data [$];
  int         rd_cyc [$];
  logic [7:0] rd_addr [$];
  int         acc_cyc [$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Bus monitor, sampled on the falling edge.
  always @(negedge clk) begin
    if (bus.rf_read && bus.rf_write) both_hi++;
    if (bus.rf_write) begin
      wr_cyc.push_back(cyc);
      wr_addr.push_back(bus.rf_addr);
      wr_data.push_back(bus.rf_wdata);
    end
    if (bus.rf_read) begin
      rd_cyc.push_back(cyc);
      rd_addr.push_back(bus.rf_addr);
    end
    if (bus.cmd_valid && bus.cmd_ready) acc_cyc.push_back(cyc);
    if (bus.rsp_valid && bus.rsp_ready) begin
      check_eq("rsp_expected", {31'b0, (sb.size() != 0)}, 32'd1);
      if (sb.size() != 0) check_eq("rsp_data", bus.rsp_data, sb.pop_front());
    end
  end

  task automatic clear_logs();
    wr_cyc.delete(); wr_addr.delete(); wr_data.delete();
    rd_cyc.delete(); rd_addr.delete(); acc_cyc.delete();
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_cmd_ready"}, bus.cmd_ready, 1);
    check_eq({tag, "_rsp_valid"}, bus.rsp_valid, 0);
    check_eq({tag, "_busy"}, bus.busy, 0);
    check_eq({tag, "_rf_write"}, bus.rf_write, 0);
    check_eq({tag, "_rf_read"}, bus.rf_read, 0);
    check_eq({tag, "_rf_addr"}, bus.rf_addr, 0);
    check_eq({tag, "_rf_wdata"}, bus.rf_wdata, 0);
    check_eq({tag, "_rsp_data"}, bus.rsp_data, 0);
  endtask

  // Present a command and hold it until accepted (bounded).
  task automatic send(input logic [1:0] op, input logic [3:0] a, input logic [3:0] a2,
                      input logic [7:0] wd);
    bit ok = 0;
    bus.cmd_op = op; bus.cmd_addr = a; bus.cmd_addr2 = a2; bus.cmd_wdata = wd;
    bus.cmd_valid = 1'b1;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if (bus.cmd_ready) begin ok = 1; break; end
    end
    check_eq("accept", {31'b0, ok}, 1);
    @(posedge clk);
    #1;
    bus.cmd_valid = 1'b0;
  endtask

  // Full command: model update, scoreboard push, latency and stall checks.
  task automatic run_cmd(input logic [1:0] op, input logic [3:0] a, input logic [3:0] a2,
                         input logic [7:0] wd, input int stall);
    logic [7:0] e;
    int lat_exp;
    int lat = 0;
    bit seen = 0;
    tick();
    case (op)
      OpRead:  begin e = exp_mem[a]; lat_exp = 2; end
      OpWrite: begin e = wd; exp_mem[a] = wd; lat_exp = 2; end
      OpMove:  begin e = exp_mem[a]; exp_mem[a2] = e; lat_exp = 3; end
      default: begin
        e = ClrData; lat_exp = Depth + 1;
        for (int i = 0; i < Depth; i++) exp_mem[i] = ClrData;
      end
    endcase
    sb.push_back(e);
    send(op, a, a2, wd);
    for (int i = 0; i < Depth + 8; i++) begin
      @(negedge clk);
      lat++;
      if (bus.rsp_valid) begin seen = 1; break; end
    end
    check_eq("rsp_latency", seen ? lat : -1, lat_exp);
    if (!seen) begin
      void'(sb.pop_back());
      return;
    end
    for (int k = 0; k < stall; k++) begin
      tick();
      // Poke a command that must be ignored while the response is pending.
      bus.cmd_op = OpWrite; bus.cmd_addr = 4'hF; bus.cmd_wdata = 8'hEE; bus.cmd_valid = 1'b1;
      @(negedge clk);
      check_eq("stall_rsp_valid", bus.rsp_valid, 1);
      check_eq("stall_rsp_data", bus.rsp_data, e);
      check_eq("stall_cmd_ready", bus.cmd_ready, 0);
    end
    tick();
    bus.cmd_valid = 1'b0;
    bus.rsp_ready = 1'b1;
    tick();
    bus.rsp_ready = 1'b0;
    @(negedge clk);
    check_eq("idle_after_rsp", {29'b0, bus.busy, bus.cmd_ready, bus.rsp_valid}, 3'b010);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int n;
    bit hit;
    rst = 1'b1;
    bus.cmd_valid = 1'b0; bus.cmd_op = 2'd0; bus.cmd_addr = '0; bus.cmd_addr2 = '0;
    bus.cmd_wdata = '0; bus.rsp_ready = 1'b0;
    for (int i = 0; i < Depth; i++) exp_mem[i] = 8'h00;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("reset");
    tick();
    rst = 1'b0;

    // WRITE then READ of the same entry.
    clear_logs();
    run_cmd(OpWrite, 4'd3, 4'd0, 8'hA5, 0);
    check_eq("wr_count", wr_addr.size(), 1);
    if (wr_addr.size() == 1) begin
      check_eq("wr_addr", wr_addr[0], 8'h03);
      check_eq("wr_data", wr_data[0], 8'hA5);
    end
    clear_logs();
    run_cmd(OpRead, 4'd3, 4'd0, 8'h00, 0);
    check_eq("rd_count", rd_addr.size(), 1);
    check_eq("rd_no_write", wr_addr.size(), 0);

    // MOVE 2 -> 9: read cycle immediately followed by write cycle.
    run_cmd(OpWrite, 4'd2, 4'd0, 8'h3C, 0);
    clear_logs();
    run_cmd(OpMove, 4'd2, 4'd9, 8'h00, 0);
    check_eq("mv_rd_count", rd_addr.size(), 1);
    check_eq("mv_wr_count", wr_addr.size(), 1);
    if (rd_addr.size() == 1 && wr_addr.size() == 1) begin
      check_eq("mv_rd_addr", rd_addr[0], 8'h02);
      check_eq("mv_wr_addr", wr_addr[0], 8'h09);
      check_eq("mv_wr_data", wr_data[0], 8'h3C);
      check_eq("mv_wr_after_rd", wr_cyc[0] - rd_cyc[0], 1);
    end
    run_cmd(OpRead, 4'd9, 4'd0, 8'h00, 0);

    // MOVE onto itself keeps the value.
    run_cmd(OpWrite, 4'd5, 4'd0, 8'h5A, 0);
    run_cmd(OpMove, 4'd5, 4'd5, 8'h00, 0);
    run_cmd(OpRead, 4'd5, 4'd0, 8'h00, 0);

    // CLEAR over a full-of-FF file.
    for (int i = 0; i < Depth; i++) run_cmd(OpWrite, 4'(i), 4'd0, 8'hFF, 0);
    clear_logs();
    run_cmd(OpClear, 4'd0, 4'd0, 8'h00, 0);
    check_eq("clr_wr_count", wr_addr.size(), Depth);
    if (wr_addr.size() == Depth) begin
      for (int i = 0; i < Depth; i++) begin
        check_eq("clr_wr_addr", wr_addr[i], i);
        check_eq("clr_wr_data", wr_data[i], ClrData);
        check_eq("clr_wr_consecutive", wr_cyc[i] - wr_cyc[0], i);
      end
    end
    for (int i = 0; i < Depth; i++) run_cmd(OpRead, 4'(i), 4'd0, 8'h00, 0);

    // READ under 10 cycles of backpressure with commands poked meanwhile.
    run_cmd(OpWrite, 4'd3, 4'd0, 8'h77, 0);
    clear_logs();
    run_cmd(OpRead, 4'd3, 4'd0, 8'h00, 10);
    check_eq("stall_no_write", wr_addr.size(), 0);
    check_eq("stall_accepts", acc_cyc.size(), 1);

    // Reset part-way through a CLEAR sweep.
    for (int i = 0; i < Depth; i++) run_cmd(OpWrite, 4'(i), 4'd0, 8'hFF, 0);
    clear_logs();
    tick();
    send(OpClear, 4'd0, 4'd0, 8'h00);
    hit = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.rf_write && bus.rf_addr == 8'd3) begin hit = 1; break; end
    end
    check_eq("clr_reach_idx3", {31'b0, hit}, 1);
    tick();
    rst = 1'b1;   // asserted during the cycle that writes index 4
    tick();
    rst = 1'b0;
    @(negedge clk);
    check_reset_outputs("midclr");
    n = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.rsp_valid || bus.busy) n++;
    end
    check_eq("midclr_no_rsp", n, 0);
    check_eq("midclr_wr_count", wr_addr.size(), 5);
    for (int i = 0; i < 5; i++) exp_mem[i] = ClrData;
    for (int i = 0; i < Depth; i++) run_cmd(OpRead, 4'(i), 4'd0, 8'h00, 0);

    // Back-to-back WRITEs with cmd_valid held high and rsp_ready held high.
    clear_logs();
    tick();
    bus.rsp_ready = 1'b1;
    bus.cmd_op = OpWrite; bus.cmd_addr = 4'd10; bus.cmd_wdata = 8'h11; bus.cmd_valid = 1'b1;
    for (int w = 0; w < 4; w++) begin
      hit = 0;
      for (int i = 0; i < 16; i++) begin
        @(negedge clk);
        if (bus.cmd_ready) begin hit = 1; break; end
      end
      check_eq("b2b_accept", {31'b0, hit}, 1);
      sb.push_back(bus.cmd_wdata);
      exp_mem[bus.cmd_addr] = bus.cmd_wdata;
      tick();
      if (w < 3) begin
        bus.cmd_addr = bus.cmd_addr + 4'd1;
        bus.cmd_wdata = bus.cmd_wdata + 8'h11;
      end else begin
        bus.cmd_valid = 1'b0;
      end
    end
    repeat (4) tick();
    bus.rsp_ready = 1'b0;
    check_eq("b2b_accepts", acc_cyc.size(), 4);
    if (acc_cyc.size() == 4) begin
      for (int i = 0; i < 3; i++) check_eq("b2b_spacing", acc_cyc[i + 1] - acc_cyc[i], 3);
    end
    check_eq("b2b_wr_count", wr_addr.size(), 4);
    if (wr_addr.size() == 4) begin
      for (int i = 0; i < 4; i++) begin
        check_eq("b2b_wr_addr", wr_addr[i], 10 + i);
        check_eq("b2b_wr_data", wr_data[i], 8'h11 * (i + 1));
      end
    end
    for (int i = 10; i < 14; i++) run_cmd(OpRead, 4'(i), 4'd0, 8'h00, 0);

    check_eq("rd_wr_overlap", both_hi, 0);
    check_eq("sb_drained", sb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
